// File: rtl/cmp_period_meter.sv
// cmp_period_meter: measures the clk-cycle period between accepted rising edges
// of the relaxation-oscillator comparator output, optionally averaged over
// 2^n periods, and issues a fixed-width discharge pulse per accepted edge.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   en_i         measurement enable (0 forces IDLE, discards partial window)
//   cmp_i        asynchronous comparator output
//   avg_sel_i    averaging exponent, clamped to MAX_AVG_LOG2
//   cmp_rst_o    discharge pulse, RST_W cycles after each accepted edge
//   count_o      averaged period in clk cycles
//   count_vld_o  one-cycle strobe when count_o/ovf_o update
//   ovf_o        window contained a saturated period
module cmp_period_meter #(
    parameter int unsigned CNT_W        = 9,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MAX_AVG_LOG2 = 3,
    parameter int unsigned BLANK        = 4,
    parameter int unsigned RST_W        = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en_i,
    input  logic                                   cmp_i,
    input  logic [$clog2(MAX_AVG_LOG2+1)-1:0]      avg_sel_i,
    output logic                                   cmp_rst_o,
    output logic [CNT_W-1:0]                       count_o,
    output logic                                   count_vld_o,
    output logic                                   ovf_o
);

    localparam int unsigned AVG_SW = $clog2(MAX_AVG_LOG2 + 1);
    localparam int unsigned ACC_W  = CNT_W + MAX_AVG_LOG2;
    localparam int unsigned WIN_W  = MAX_AVG_LOG2 + 1;
    localparam int unsigned BLK_W  = $clog2(BLANK + 1);
    localparam int unsigned RCW    = $clog2(RST_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    // Comparator synchroniser plus edge-detect delay flop
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
    logic                sat_q,     sat_d;
    logic [BLK_W-1:0]    blank_q,   blank_d;
    logic [RCW-1:0]      rcnt_q,    rcnt_d;
    logic                cmp_rst_q, cmp_rst_d;
    logic [ACC_W-1:0]    acc_q,     acc_d;
    logic [WIN_W-1:0]    win_q,     win_d;
    logic                wovf_q,    wovf_d;
    logic [AVG_SW-1:0]   nlat_q,    nlat_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic                ovf_q,     ovf_d;
    logic                vld_q,     vld_d;

    logic                raw_evt;
    logic                acc_evt;
    logic                win_last;
    logic [ACC_W-1:0]    period_sum;
    logic [AVG_SW-1:0]   sel_clamp;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            sat_q     <= 1'b0;
            blank_q   <= '0;
            rcnt_q    <= '0;
            cmp_rst_q <= 1'b0;
            acc_q     <= '0;
            win_q     <= '0;
            wovf_q    <= 1'b0;
            nlat_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            sat_q     <= sat_d;
            blank_q   <= blank_d;
            rcnt_q    <= rcnt_d;
            cmp_rst_q <= cmp_rst_d;
            acc_q     <= acc_d;
            win_q     <= win_d;
            wovf_q    <= wovf_d;
            nlat_q    <= nlat_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            vld_q     <= vld_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        sat_d     = sat_q;
        blank_d   = blank_q;
        rcnt_d    = rcnt_q;
        acc_d     = acc_q;
        win_d     = win_q;
        wovf_d    = wovf_q;
        nlat_d    = nlat_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        vld_d     = 1'b0;

        raw_evt    = sync_q[SYNC_STAGES-1] & ~dly_q;
        acc_evt    = raw_evt && (blank_q == '0) && (state_q != IDLE);
        period_sum = acc_q + ACC_W'(clk_cnt_q);
        // Window closes on its 2^n-th period
        win_last   = (win_q == ((WIN_W'(1) << nlat_q) - WIN_W'(1)));
        sel_clamp  = (avg_sel_i > AVG_SW'(MAX_AVG_LOG2)) ? AVG_SW'(MAX_AVG_LOG2) : avg_sel_i;

        if (!en_i) begin
            state_d   = IDLE;
            clk_cnt_d = '0;
            sat_d     = 1'b0;
            blank_d   = '0;
            rcnt_d    = '0;
            acc_d     = '0;
            win_d     = '0;
            wovf_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (acc_evt) begin
                        state_d = MEAS;
                        nlat_d  = sel_clamp;
                        acc_d   = '0;
                        win_d   = '0;
                        wovf_d  = 1'b0;
                    end
                end
                MEAS: begin
                    if (acc_evt) begin
                        if (win_last) begin
                            count_d = CNT_W'(period_sum >> nlat_q);
                            ovf_d   = wovf_q | sat_q;
                            vld_d   = 1'b1;
                            acc_d   = '0;
                            win_d   = '0;
                            wovf_d  = 1'b0;
                            nlat_d  = sel_clamp;
                        end else begin
                            acc_d  = period_sum;
                            win_d  = win_q + WIN_W'(1);
                            wovf_d = wovf_q | sat_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Period counter, blanking and discharge timer run in ARM and MEAS
            if (state_q != IDLE) begin
                if (acc_evt) begin
                    clk_cnt_d = CNT_W'(1);
                    sat_d     = 1'b0;
                    blank_d   = BLK_W'(BLANK);
                    rcnt_d    = RCW'(RST_W);
                end else begin
                    // Saturation means the true period exceeded CNT_MAX
                    if (clk_cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        clk_cnt_d = clk_cnt_q + CNT_W'(1);
                    end
                    if (blank_q != '0) begin
                        blank_d = blank_q - BLK_W'(1);
                    end
                    if (rcnt_q != '0) begin
                        rcnt_d = rcnt_q - RCW'(1);
                    end
                end
            end
        end

        cmp_rst_d = (rcnt_d != '0);
    end

    assign cmp_rst_o   = cmp_rst_q;
    assign count_o     = count_q;
    assign count_vld_o = vld_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_cmp_period_meter.sv
// Directed testbench for cmp_period_meter (default parameters).
module tb_cmp_period_meter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       cmp;
    logic [1:0] avg_sel;
    logic       cmp_rst;
    logic [8:0] count;
    logic       count_vld;
    logic       ovf;

    int checks;
    int errors;
    int cyc;
    int vld_cnt;
    int rst_cyc;
    int vld_cyc;
    int rise_cyc;
    logic [8:0] last_count;
    logic       last_ovf;

    cmp_period_meter dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .cmp_i       (cmp),
        .avg_sel_i   (avg_sel),
        .cmp_rst_o   (cmp_rst),
        .count_o     (count),
        .count_vld_o (count_vld),
        .ovf_o       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (count_vld === 1'b1) begin
            vld_cnt    = vld_cnt + 1;
            last_count = count;
            last_ovf   = ovf;
            vld_cyc    = cyc;
        end
        if (cmp_rst === 1'b1) rst_cyc = rst_cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic clr_mon();
        vld_cnt = 0;
        rst_cyc = 0;
    endtask

    // Rising cmp edge now (at a negedge), next edge 'gap' cycles later
    task automatic pulse(input int gap);
        cmp      = 1'b1;
        rise_cyc = cyc;
        repeat (2) @(negedge clk);
        cmp = 1'b0;
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic rearm(input logic [1:0] sel);
        en = 1'b0;
        repeat (3) @(negedge clk);
        avg_sel = sel;
        en      = 1'b1;
        repeat (3) @(negedge clk);
        clr_mon();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cmp = 1'b0; avg_sel = 2'd0;
        repeat (3) @(negedge clk);
        checks++; if (count !== 9'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (count_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", count_vld); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (cmp_rst !== 1'b0) begin errors++; $display("FAIL reset_cmp_rst: got %b expected 0", cmp_rst); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_period();
        rearm(2'd0);
        pulse(20);
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL first_edge_vld: got %0d expected 0", vld_cnt); end
        checks++; if (rst_cyc !== 2) begin errors++; $display("FAIL first_edge_cmp_rst: got %0d cycles expected 2", rst_cyc); end
        checks++; if (count !== 9'd0) begin errors++; $display("FAIL first_edge_count: got %0d expected 0", count); end
        for (int i = 0; i < 3; i++) begin
            clr_mon();
            pulse(20);
            checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL single_vld[%0d]: got %0d cycles expected 1", i, vld_cnt); end
            checks++; if (last_count !== 9'd20) begin errors++; $display("FAIL single_count[%0d]: got %0d expected 20", i, last_count); end
            checks++; if (last_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf[%0d]: got %b expected 0", i, last_ovf); end
            checks++; if (vld_cyc - rise_cyc !== 3) begin errors++; $display("FAIL single_latency[%0d]: got %0d expected 3", i, vld_cyc - rise_cyc); end
            checks++; if (rst_cyc !== 2) begin errors++; $display("FAIL single_cmp_rst[%0d]: got %0d expected 2", i, rst_cyc); end
        end
    endtask

    task automatic test_average();
        rearm(2'd2);
        pulse(10);
        avg_sel = 2'd0;   // mid-window change must be ignored
        pulse(11);
        pulse(12);
        avg_sel = 2'd2;
        pulse(13);
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL avg_early_vld: got %0d expected 0", vld_cnt); end
        pulse(20);
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL avg_vld: got %0d expected 1", vld_cnt); end
        checks++; if (last_count !== 9'd11) begin errors++; $display("FAIL avg_count: got %0d expected 11", last_count); end
        checks++; if (last_ovf !== 1'b0) begin errors++; $display("FAIL avg_ovf: got %b expected 0", last_ovf); end
        clr_mon();
        pulse(24);
        pulse(28);
        pulse(32);
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL avg2_early_vld: got %0d expected 0", vld_cnt); end
        pulse(10);
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL avg2_vld: got %0d expected 1", vld_cnt); end
        checks++; if (last_count !== 9'd26) begin errors++; $display("FAIL avg2_count: got %0d expected 26", last_count); end
    endtask

    task automatic test_saturation();
        rearm(2'd0);
        pulse(600);
        clr_mon();
        pulse(30);
        checks++; if (last_count !== 9'd511) begin errors++; $display("FAIL sat_count: got %0d expected 511", last_count); end
        checks++; if (last_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", last_ovf); end
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL sat_vld: got %0d expected 1", vld_cnt); end
        clr_mon();
        pulse(10);
        checks++; if (last_count !== 9'd30) begin errors++; $display("FAIL post_sat_count: got %0d expected 30", last_count); end
        checks++; if (last_ovf !== 1'b0) begin errors++; $display("FAIL post_sat_ovf: got %b expected 0", last_ovf); end
    endtask

    task automatic test_blanking();
        rearm(2'd0);
        pulse(20);
        clr_mon();
        // accepted edge, second raw edge 2 cycles later, next edge 8 cycles after the first
        cmp = 1'b1;
        @(negedge clk); cmp = 1'b0;
        @(negedge clk); cmp = 1'b1;
        @(negedge clk);
        @(negedge clk); cmp = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL blank_vld: got %0d expected 1", vld_cnt); end
        checks++; if (last_count !== 9'd20) begin errors++; $display("FAIL blank_prev_count: got %0d expected 20", last_count); end
        checks++; if (rst_cyc !== 2) begin errors++; $display("FAIL blank_cmp_rst: got %0d cycles expected 2", rst_cyc); end
        clr_mon();
        pulse(10);
        checks++; if (last_count !== 9'd8) begin errors++; $display("FAIL blank_period: got %0d expected 8", last_count); end
        checks++; if (rst_cyc !== 2) begin errors++; $display("FAIL blank_next_cmp_rst: got %0d cycles expected 2", rst_cyc); end
    endtask

    task automatic test_en_drop();
        rearm(2'd1);
        pulse(15);
        pulse(15);
        en = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL endrop_vld: got %0d expected 0", vld_cnt); end
        checks++; if (count !== 9'd8) begin errors++; $display("FAIL endrop_count_hold: got %0d expected 8", count); end
        en = 1'b1;
        repeat (3) @(negedge clk);
        clr_mon();
        pulse(14);
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL rearm_first_vld: got %0d expected 0", vld_cnt); end
        checks++; if (count !== 9'd8) begin errors++; $display("FAIL rearm_count_hold: got %0d expected 8", count); end
        checks++; if (rst_cyc !== 2) begin errors++; $display("FAIL rearm_cmp_rst: got %0d cycles expected 2", rst_cyc); end
        pulse(17);
        pulse(10);
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL rearm_vld: got %0d expected 1", vld_cnt); end
        checks++; if (last_count !== 9'd15) begin errors++; $display("FAIL rearm_count: got %0d expected 15", last_count); end
    endtask

    task automatic test_async_reset();
        rearm(2'd0);
        pulse(20);
        cmp = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (cmp_rst !== 1'b1) begin errors++; $display("FAIL pre_rst_cmp_rst: got %b expected 1", cmp_rst); end
        checks++; if (count !== 9'd20) begin errors++; $display("FAIL pre_rst_count: got %0d expected 20", count); end
        #1 rst = 1'b1;
        #1;
        checks++; if (count !== 9'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", count); end
        checks++; if (count_vld !== 1'b0) begin errors++; $display("FAIL arst_vld: got %b expected 0", count_vld); end
        checks++; if (cmp_rst !== 1'b0) begin errors++; $display("FAIL arst_cmp_rst: got %b expected 0", cmp_rst); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf: got %b expected 0", ovf); end
        @(negedge clk); cmp = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        clr_mon();
        pulse(25);
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL post_rst_first_vld: got %0d expected 0", vld_cnt); end
        checks++; if (rst_cyc !== 2) begin errors++; $display("FAIL post_rst_cmp_rst: got %0d cycles expected 2", rst_cyc); end
        pulse(10);
        checks++; if (last_count !== 9'd25) begin errors++; $display("FAIL post_rst_count: got %0d expected 25", last_count); end
    endtask

    task automatic test_avg_clamp();
        logic [2:0] sel_raw;
        sel_raw = 3'd7;
        rearm(2'(sel_raw));
        for (int g = 10; g < 18; g++) pulse(g);
        checks++; if (vld_cnt !== 0) begin errors++; $display("FAIL clamp_early_vld: got %0d expected 0", vld_cnt); end
        pulse(20);
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL clamp_vld: got %0d expected 1", vld_cnt); end
        checks++; if (last_count !== 9'd13) begin errors++; $display("FAIL clamp_count: got %0d expected 13", last_count); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        vld_cnt = 0;
        rst_cyc = 0;
        vld_cyc = 0;
        rise_cyc = 0;
        last_count = '0;
        last_ovf   = 1'b0;
        test_reset();
        test_single_period();
        test_average();
        test_saturation();
        test_blanking();
        test_en_drop();
        test_async_reset();
        test_avg_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
